// File: rtl/config_manager_uc.sv
// config_manager_uc: control unit for the serial configuration path.
// Pairs a command word with a data word, validates both and pulses the
// one limit-register load enable for the addressed target. Keeps sticky
// "configured" flags and the code of the last error.
module config_manager_uc #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter logic [15:0] UMID_MAX       = 16'd1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        configurar,
  input  logic        fim_recepcao_config,
  input  logic        parity_config_ok,
  input  logic [15:0] config_data,
  output logic        load_lim_um,
  output logic        load_temp1,
  output logic        load_temp2,
  output logic        load_temp3,
  output logic        load_temp4,
  output logic        config_ok,
  output logic        config_err,
  output logic [2:0]  err_code,
  output logic [4:0]  configurados,
  output logic        todos_configurados,
  output logic [3:0]  db_estado
);

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    ESPERA_CMD = 4'd1,
    DECODIFICA = 4'd2,
    ESPERA_DADO= 4'd3,
    VALIDA     = 4'd4,
    CARREGA    = 4'd5,
    FIM_OK     = 4'd6,
    ERRO       = 4'd7
  } state_t;

  localparam logic [25:0] TMO_LAST = 26'(TIMEOUT_CYCLES - 1);
  localparam logic [25:0] CNT_MAX  = '1;

  state_t      state_q, state_d;
  logic [2:0]  tgt_q, tgt_d;
  logic [25:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
  logic        par_q, par_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [4:0]  conf_q, conf_d;
  logic [4:0]  ld;

  // One-hot load vector, only ever non-zero in CARREGA (target is <= 4 there)
  always_comb begin
    ld = 5'b0;
    if (state_q == CARREGA) ld = 5'b00001 << tgt_q;
  end

  // Next-state, counter, latched parity, error code and sticky flags
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    par_d      = par_q;
    err_code_d = err_code_q;
    conf_d     = conf_q | ld;
    // Registered "reached the last wait cycle" flag; error fires one cycle later
    tmo_d      = (state_q == ESPERA_DADO) && (cnt_q == TMO_LAST);

    // Parity is only meaningful alongside fim, so capture it there
    if (fim_recepcao_config && (state_q == ESPERA_CMD || state_q == ESPERA_DADO))
      par_d = parity_config_ok;

    if (state_q == ESPERA_DADO && cnt_q != CNT_MAX)
      cnt_d = cnt_q + 26'd1;

    case (state_q)
      INICIAL: if (configurar) state_d = ESPERA_CMD;
      ESPERA_CMD: begin
        if (fim_recepcao_config) state_d = DECODIFICA;
        else if (!configurar)    state_d = INICIAL;
      end
      DECODIFICA: begin
        if (!par_q) begin
          state_d = ERRO; err_code_d = 3'd1;
        end else if (config_data[15:8] != 8'hA5) begin
          state_d = ERRO; err_code_d = 3'd2;
        end else if (config_data[2:0] > 3'd4) begin
          state_d = ERRO; err_code_d = 3'd3;
        end else begin
          state_d = ESPERA_DADO;
          tgt_d   = config_data[2:0];
          cnt_d   = '0;
        end
      end
      ESPERA_DADO: begin
        // The frame's own fim wins over a simultaneous timeout
        if (fim_recepcao_config) state_d = VALIDA;
        else if (tmo_q) begin
          state_d = ERRO; err_code_d = 3'd4;
        end else if (!configurar) state_d = INICIAL;
      end
      VALIDA: begin
        if (!par_q) begin
          state_d = ERRO; err_code_d = 3'd1;
        end else if (tgt_q == 3'd0 && config_data > UMID_MAX) begin
          state_d = ERRO; err_code_d = 3'd5;
        end else state_d = CARREGA;
      end
      CARREGA: state_d = FIM_OK;
      FIM_OK:  state_d = ESPERA_CMD;
      ERRO:    state_d = ESPERA_CMD;
      default: state_d = INICIAL;
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= INICIAL;
      tgt_q      <= '0;
      cnt_q      <= '0;
      tmo_q      <= 1'b0;
      par_q      <= 1'b0;
      err_code_q <= '0;
      conf_q     <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      par_q      <= par_d;
      err_code_q <= err_code_d;
      conf_q     <= conf_d;
    end
  end

  assign load_lim_um        = ld[0];
  assign load_temp1         = ld[1];
  assign load_temp2         = ld[2];
  assign load_temp3         = ld[3];
  assign load_temp4         = ld[4];
  assign config_ok          = (state_q == FIM_OK);
  assign config_err         = (state_q == ERRO);
  assign err_code           = err_code_q;
  assign configurados       = conf_q;
  assign todos_configurados = &conf_q;
  assign db_estado          = state_q;

endmodule

// File: tb/tb_config_manager_uc.sv
// Self-checking bench for config_manager_uc: vector table, hand-written
// timing sequences and randomized transactions against a reference model.
module tb_config_manager_uc;

  localparam int T = 100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        configurar = 1'b0;
  logic        fim = 1'b0;
  logic        parity = 1'b1;
  logic [15:0] config_data = '0;
  logic        load_lim_um, load_temp1, load_temp2, load_temp3, load_temp4;
  logic        config_ok, config_err, todos_configurados;
  logic [2:0]  err_code;
  logic [4:0]  configurados;
  logic [3:0]  db_estado;

  config_manager_uc #(.TIMEOUT_CYCLES(T), .UMID_MAX(16'd1000)) dut (
    .clock(clock), .reset(reset), .configurar(configurar),
    .fim_recepcao_config(fim), .parity_config_ok(parity), .config_data(config_data),
    .load_lim_um(load_lim_um), .load_temp1(load_temp1), .load_temp2(load_temp2),
    .load_temp3(load_temp3), .load_temp4(load_temp4),
    .config_ok(config_ok), .config_err(config_err), .err_code(err_code),
    .configurados(configurados), .todos_configurados(todos_configurados),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Output monitor: counts pulses and records when they happened
  int          ld_cnt [5] = '{0, 0, 0, 0, 0};
  logic [15:0] ld_val [5] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
  int ok_cnt = 0, err_cnt = 0, multi_cnt = 0;
  int last_ld_cyc = 0, last_ok_cyc = 0, last_err_cyc = 0;
  always @(negedge clock) begin
    logic [4:0] lds;
    lds = {load_temp4, load_temp3, load_temp2, load_temp1, load_lim_um};
    if ($countones(lds) > 1) multi_cnt++;
    for (int i = 0; i < 5; i++)
      if (lds[i]) begin ld_cnt[i]++; ld_val[i] = config_data; last_ld_cyc = cyc; end
    if (config_ok)  begin ok_cnt++;  last_ok_cyc  = cyc; end
    if (config_err) begin err_cnt++; last_err_cyc = cyc; end
  end

  int checks = 0, failures = 0;
  logic [4:0] mdl_conf = '0;
  logic [2:0] mdl_err  = '0;
  int fim_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int ld_total();
    int s = 0;
    for (int i = 0; i < 5; i++) s += ld_cnt[i];
    return s;
  endfunction

  // Reference model: outcome of one command/data pair from the protocol rules
  function automatic int predict(input logic [15:0] c, input logic cp,
                                 input logic [15:0] d, input logic dp);
    if (!cp) return 1;
    if (c[15:8] != 8'hA5) return 2;
    if (c[2:0] > 3'd4) return 3;
    if (!dp) return 1;
    if (c[2:0] == 3'd0 && d > 16'd1000) return 5;
    return 0;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input logic [15:0] w, input logic p);
    @(negedge clock);
    config_data = w; parity = p; fim = 1'b1; fim_cyc = cyc;
    @(negedge clock);
    fim = 1'b0;
  endtask

  // One full transaction; data frame only follows a command that decodes cleanly
  task automatic txn(input string nm, input logic [15:0] c, input logic cp,
                     input logic [15:0] d, input logic dp, input int exp);
    int ld0, ok0, er0, cfc, dfc, tg;
    logic cmd_ok;
    ld0 = ld_total(); ok0 = ok_cnt; er0 = err_cnt;
    tg  = int'(c[2:0]);
    cmd_ok = cp && c[15:8] == 8'hA5 && c[2:0] <= 3'd4;
    send(c, cp); cfc = fim_cyc; idle(5);
    dfc = 0;
    if (cmd_ok) begin send(d, dp); dfc = fim_cyc; idle(5); end
    if (exp == 0) begin
      mdl_conf[tg] = 1'b1;
      chk({nm, " ok_pulses"},  ok_cnt - ok0, 1);
      chk({nm, " err_pulses"}, err_cnt - er0, 0);
      chk({nm, " loads"},      ld_total() - ld0, 1);
      chk({nm, " ld_value"},   ld_val[tg], d);
      chk({nm, " ld_latency"}, last_ld_cyc - dfc, 2);
      chk({nm, " ok_latency"}, last_ok_cyc - dfc, 3);
    end else begin
      mdl_err = 3'(exp);
      chk({nm, " ok_pulses"},  ok_cnt - ok0, 0);
      chk({nm, " err_pulses"}, err_cnt - er0, 1);
      chk({nm, " loads"},      ld_total() - ld0, 0);
      chk({nm, " err_latency"}, last_err_cyc - (cmd_ok ? dfc : cfc), 2);
    end
    chk({nm, " err_code"},     err_code, mdl_err);
    chk({nm, " configurados"}, configurados, mdl_conf);
    chk({nm, " todos"},        todos_configurados, &mdl_conf);
    chk({nm, " db_estado"},    db_estado, 1);
  endtask

  typedef struct {
    logic [15:0] cmd; logic cp; logic [15:0] data; logic dp; int code;
  } vec_t;
  vec_t tbl [15];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ld0, ok0, er0, ent, found;
    tbl[0]  = '{16'hA502, 1'b1, 16'h0190, 1'b1, 0};
    tbl[1]  = '{16'hA500, 1'b1, 16'd1001, 1'b1, 5};
    tbl[2]  = '{16'hA500, 1'b1, 16'd1000, 1'b1, 0};
    tbl[3]  = '{16'h5A01, 1'b1, 16'h0000, 1'b1, 2};
    tbl[4]  = '{16'hA506, 1'b1, 16'h0000, 1'b1, 3};
    tbl[5]  = '{16'hA501, 1'b0, 16'h0000, 1'b1, 1};
    tbl[6]  = '{16'hA504, 1'b1, 16'h0123, 1'b0, 1};
    tbl[7]  = '{16'hA5F9, 1'b1, 16'h7FFF, 1'b1, 0};
    tbl[8]  = '{16'hA500, 1'b1, 16'h0000, 1'b1, 0};
    tbl[9]  = '{16'hA503, 1'b1, 16'hFFFF, 1'b1, 0};
    tbl[10] = '{16'hA505, 1'b1, 16'h0000, 1'b1, 3};
    tbl[11] = '{16'hA507, 1'b1, 16'h0000, 1'b1, 3};
    tbl[12] = '{16'h0000, 1'b1, 16'h0000, 1'b1, 2};
    tbl[13] = '{16'hA507, 1'b0, 16'h0000, 1'b1, 1};
    tbl[14] = '{16'h5A07, 1'b1, 16'h0000, 1'b1, 2};

    // Reset state
    idle(2);
    chk("rst db_estado", db_estado, 0);
    chk("rst loads", {load_temp4, load_temp3, load_temp2, load_temp1, load_lim_um}, 0);
    chk("rst ok_err", {config_ok, config_err}, 0);
    chk("rst err_code", err_code, 0);
    chk("rst configurados", configurados, 0);
    reset = 1'b0;
    idle(2);
    chk("idle inicial", db_estado, 0);
    configurar = 1'b1;
    idle(2);
    chk("espera_cmd", db_estado, 1);

    // Vector table
    for (int i = 0; i < 15; i++)
      txn($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].cp, tbl[i].data, tbl[i].dp, tbl[i].code);

    // Timeout: command accepted, no data frame
    ld0 = ld_total(); ok0 = ok_cnt; er0 = err_cnt;
    send(16'hA503, 1'b1);
    ent = -1;
    for (int i = 0; i < 10 && ent < 0; i++) begin
      if (db_estado == 4'd3) ent = cyc;
      else @(negedge clock);
    end
    chk("tmo entered espera_dado", ent >= 0, 1);
    found = -1;
    for (int i = 0; i < 3 * T && found < 0; i++) begin
      @(negedge clock);
      if (config_err) found = cyc;
    end
    chk("tmo err_delay", found - ent, T + 1);
    idle(3);
    mdl_err = 3'd4;
    chk("tmo err_code", err_code, 4);
    chk("tmo loads", ld_total() - ld0, 0);
    chk("tmo ok_pulses", ok_cnt - ok0, 0);
    chk("tmo err_pulses", err_cnt - er0, 1);
    txn("after_tmo", 16'hA503, 1'b1, 16'h0222, 1'b1, 0);

    // configurar dropped while waiting for data
    ld0 = ld_total(); ok0 = ok_cnt; er0 = err_cnt;
    send(16'hA501, 1'b1);
    idle(2);
    chk("drop in espera_dado", db_estado, 3);
    configurar = 1'b0;
    idle(2);
    chk("drop to inicial", db_estado, 0);
    send(16'h0050, 1'b1);
    idle(5);
    chk("drop loads", ld_total() - ld0, 0);
    chk("drop ok_pulses", ok_cnt - ok0, 0);
    chk("drop err_pulses", err_cnt - er0, 0);
    chk("drop db_estado", db_estado, 0);
    configurar = 1'b1;
    idle(2);

    // Randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      logic [15:0] c, d;
      logic cp, dp;
      c[15:8] = ($urandom_range(3) != 0) ? 8'hA5 : 8'($urandom_range(255));
      c[7:0]  = 8'($urandom_range(255));
      cp = ($urandom_range(7) != 0);
      d  = $urandom_range(1) ? 16'(990 + $urandom_range(20)) : 16'($urandom_range(65535));
      dp = ($urandom_range(7) != 0);
      txn($sformatf("rnd%0d", i), c, cp, d, dp, predict(c, cp, d, dp));
    end

    // Configure every target from a cleared state
    reset = 1'b1; idle(1); reset = 1'b0;
    mdl_conf = '0; mdl_err = '0;
    idle(2);
    chk("clear configurados", configurados, 0);
    for (int t = 0; t < 5; t++)
      txn($sformatf("all%0d", t), 16'hA500 | 16'(t), 1'b1, 16'(100 + t), 1'b1, 0);
    chk("todos after five", todos_configurados, 1);

    // Reset asserted mid-transaction, right after the data frame
    ld0 = ld_total(); ok0 = ok_cnt;
    send(16'hA502, 1'b1);
    idle(3);
    send(16'h1234, 1'b1);
    reset = 1'b1;
    idle(4);
    chk("midrst loads", ld_total() - ld0, 0);
    chk("midrst ok_pulses", ok_cnt - ok0, 0);
    chk("midrst configurados", configurados, 0);
    chk("midrst todos", todos_configurados, 0);
    chk("midrst err_code", err_code, 0);
    chk("midrst db_estado", db_estado, 0);
    reset = 1'b0;
    idle(2);
    chk("load one-hot", multi_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
